// File: rtl/load_extend_pipe_if.sv
// rtl/load_extend_pipe_if.sv - Handshake bundle for the load extend pipeline
//
// Groups the input item channel and the output result channel of
// load_extend_pipe. out_misalign exists only when LOAD_EXTEND_ALIGN_CHECK_EN
// is defined.
//
// Signals:
//   in_valid/in_ready   input handshake
//   in_data             raw memory word (DATA_W)
//   in_offset           byte address low bits (OFF_W)
//   in_size             0=byte, 1=halfword, 2/3=full word
//   in_sign             1=sign-extend, 0=zero-extend
//   in_tag              sideband tag (TAG_W)
//   out_valid/out_ready output handshake
//   out_data            extended result (DATA_W)
//   out_tag             tag paired with out_data
//   out_misalign        misaligned access flag (optional)
//
// Modports: master drives items in and consumes results; slave is the pipe.
interface load_extend_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_offset;
  logic [1:0]        in_size;
  logic              in_sign;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
  logic              out_misalign;

  modport master (
    output in_valid, in_data, in_offset, in_size, in_sign, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_misalign
  );
  modport slave (
    input  in_valid, in_data, in_offset, in_size, in_sign, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_misalign
  );
`else
  modport master (
    output in_valid, in_data, in_offset, in_size, in_sign, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  in_valid, in_data, in_offset, in_size, in_sign, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
`endif
endinterface

// File: rtl/load_extend_pipe.sv
// rtl/load_extend_pipe.sv - Two-stage load lane select and sign/zero extend
//
// Stage 1 selects the addressed byte/halfword lane of the memory word;
// stage 2 sign- or zero-extends it to DATA_W. Valid/ready handshake on both
// ends, one item per cycle sustained, tag carried alongside each item.
// Optional build macro LOAD_EXTEND_ALIGN_CHECK_EN adds out_misalign and
// zeroes the data of misaligned halfword/word accesses.
//
// Ports:
//   clk  clock, all state on rising edge
//   rst  synchronous active-high reset
//   bus  load_extend_pipe_if.slave (input items, output results)
module load_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  load_extend_pipe_if.slave   bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DATA_W);

  // Stage 1 (aligned lane) registers
  logic              v1;
  logic [DATA_W-1:0] s1_lane;
  logic [1:0]        s1_size;
  logic              s1_sign;
  logic [TAG_W-1:0]  s1_tag;

  // Stage 2 (result) registers
  logic              v2;
  logic [DATA_W-1:0] out_data_q;
  logic [TAG_W-1:0]  out_tag_q;

  logic              load1;
  logic              load2;
  logic [1:0]        eff_size;
  logic [IDX_W-1:0]  byte_base;
  logic [IDX_W-1:0]  half_base;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] ext;
  logic              fill;

`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
  logic misalign;
  logic s1_misalign;
  logic out_misalign_q;
`endif

  // A stage may load when empty or when the stage after it empties this cycle.
  assign load2 = !v2 || bus.out_ready;
  assign load1 = !v1 || load2;

  assign bus.in_ready  = !rst && load1;
  assign bus.out_valid = v2;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
  assign bus.out_misalign = out_misalign_q;
`endif

  // Lane select. Offset*8 is the byte bit position; clearing bit 3 of that
  // rounds it down to the enclosing halfword.
  always_comb begin
    eff_size  = (bus.in_size == 2'd3) ? 2'd2 : bus.in_size;
    byte_base = {bus.in_offset, 3'b000};
    half_base = byte_base;
    half_base[3] = 1'b0;
    lane = '0;
    case (eff_size)
      2'd0:    lane[7:0]  = bus.in_data[byte_base +: 8];
      2'd1:    lane[15:0] = bus.in_data[half_base +: 16];
      default: lane       = bus.in_data;
    endcase
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    misalign = ((eff_size == 2'd1) && bus.in_offset[0]) ||
               ((eff_size == 2'd2) && (bus.in_offset != '0));
    // Flagged items keep flowing with zero data; the exception is raised later.
    if (misalign) lane = '0;
`endif
  end

  // Extension of the registered lane.
  always_comb begin
    fill = s1_sign && ((s1_size == 2'd0) ? s1_lane[7] : s1_lane[15]);
    ext  = {DATA_W{fill}};
    case (s1_size)
      2'd0:    ext[7:0]  = s1_lane[7:0];
      2'd1:    ext[15:0] = s1_lane[15:0];
      default: ext       = s1_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      s1_lane    <= '0;
      s1_size    <= '0;
      s1_sign    <= 1'b0;
      s1_tag     <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
      s1_misalign    <= 1'b0;
      out_misalign_q <= 1'b0;
`endif
    end else begin
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          out_data_q <= ext;
          out_tag_q  <= s1_tag;
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
          out_misalign_q <= s1_misalign;
`endif
        end
      end
      if (load1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          s1_lane <= lane;
          s1_size <= eff_size;
          s1_sign <= bus.in_sign;
          s1_tag  <= bus.in_tag;
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
          s1_misalign <= misalign;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_load_extend_pipe.sv
// tb/tb_load_extend_pipe.sv - Directed bench for load_extend_pipe
module tb_load_extend_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  load_extend_pipe_if #(.DATA_W(32), .TAG_W(5)) bus ();

  load_extend_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  tag;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stream_word(input logic [4:0] tag);
    logic [31:0] d;
    d = 32'h1122_3344;
    d[8*(tag%4) +: 8] = 8'h80 + 8'(tag);
    return d;
  endfunction

  // Stream test state
  logic [31:0] exp_q_data[$];
  logic [4:0]  exp_q_tag[$];
  logic        m_v1, m_v2, m_in_ready, fire_in, drain;
  logic        prev_stall;
  logic [31:0] held_data;
  logic [4:0]  held_tag;
  int          sent, got;
  logic        pat[4];

  initial begin
    vecs[0]  = '{32'h8077_F0A5, 2'd3, 2'd0, 1'b1, 5'd1,  32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{32'h8077_F0A5, 2'd0, 2'd0, 1'b1, 5'd2,  32'hFFFF_FFA5, 1'b0};
    vecs[2]  = '{32'h8077_F0A5, 2'd2, 2'd1, 1'b0, 5'd3,  32'h0000_8077, 1'b0};
    vecs[3]  = '{32'h8077_F0A5, 2'd2, 2'd1, 1'b1, 5'd4,  32'hFFFF_8077, 1'b0};
    vecs[4]  = '{32'h8077_F0A5, 2'd0, 2'd1, 1'b1, 5'd5,  32'hFFFF_F0A5, 1'b0};
    vecs[5]  = '{32'h8000_0001, 2'd0, 2'd2, 1'b1, 5'd6,  32'h8000_0001, 1'b0};
    vecs[6]  = '{32'h8077_F0A5, 2'd1, 2'd0, 1'b0, 5'd7,  32'h0000_00F0, 1'b0};
    vecs[7]  = '{32'h1234_5678, 2'd0, 2'd3, 1'b1, 5'd8,  32'h1234_5678, 1'b0};
    vecs[8]  = '{32'h8077_F0A5, 2'd2, 2'd0, 1'b1, 5'd9,  32'h0000_0077, 1'b0};
    vecs[12] = '{32'h8077_F0A5, 2'd1, 2'd0, 1'b1, 5'd13, 32'hFFFF_FFF0, 1'b0};
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    vecs[9]  = '{32'h8077_F0A5, 2'd3, 2'd1, 1'b0, 5'd10, 32'h0000_0000, 1'b1};
    vecs[10] = '{32'h8077_F0A5, 2'd2, 2'd2, 1'b1, 5'd11, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'h8077_F0A5, 2'd1, 2'd1, 1'b1, 5'd12, 32'h0000_0000, 1'b1};
`else
    vecs[9]  = '{32'h8077_F0A5, 2'd3, 2'd1, 1'b0, 5'd10, 32'h0000_8077, 1'b0};
    vecs[10] = '{32'h8077_F0A5, 2'd2, 2'd2, 1'b1, 5'd11, 32'h8077_F0A5, 1'b0};
    vecs[11] = '{32'h8077_F0A5, 2'd1, 2'd1, 1'b1, 5'd12, 32'hFFFF_F0A5, 1'b0};
`endif
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_offset = '0;
    bus.in_size   = '0;
    bus.in_sign   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_in_ready_after", 32'(bus.in_ready), 32'd1);
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
    chk("rst_misalign", 32'(bus.out_misalign), 32'd0);
`endif

    // Single-item vectors: check two-cycle latency and the result
    for (int i = 0; i < 13; i++) begin
      bus.in_data   = vecs[i].data;
      bus.in_offset = vecs[i].off;
      bus.in_size   = vecs[i].size;
      bus.in_sign   = vecs[i].sign;
      bus.in_tag    = vecs[i].tag;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_lat1_valid", i), 32'(bus.out_valid), 32'd0);
      step();
      chk($sformatf("v%0d_lat2_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_data", i), bus.out_data, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), 32'(bus.out_tag), 32'(vecs[i].tag));
`ifdef LOAD_EXTEND_ALIGN_CHECK_EN
      chk($sformatf("v%0d_mis", i), 32'(bus.out_misalign), 32'(vecs[i].mis));
`endif
      step();
    end

    // Back-to-back stream with out_ready pattern 1,0,0,1
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    sent = 0;
    got  = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      bus.out_ready = pat[c % 4];
      if (sent < 8) begin
        bus.in_valid  = 1'b1;
        bus.in_tag    = 5'(sent + 1);
        bus.in_data   = stream_word(5'(sent + 1));
        bus.in_offset = 2'((sent + 1) % 4);
        bus.in_size   = 2'd0;
        bus.in_sign   = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      m_in_ready = !m_v1 || !m_v2 || bus.out_ready;
      chk($sformatf("s%0d_in_ready", c), 32'(bus.in_ready), 32'(m_in_ready));
      chk($sformatf("s%0d_out_valid", c), 32'(bus.out_valid), 32'(m_v2));
      if (prev_stall) begin
        chk($sformatf("s%0d_hold_data", c), bus.out_data, held_data);
        chk($sformatf("s%0d_hold_tag", c), 32'(bus.out_tag), 32'(held_tag));
      end
      fire_in = bus.in_valid && m_in_ready;
      drain   = m_v2 && bus.out_ready;
      if (drain) begin
        if (exp_q_tag.size() == 0) begin
          chk($sformatf("s%0d_unexpected", c), 32'(bus.out_tag), 32'h0);
          errors++;
        end else begin
          chk($sformatf("s%0d_tag", c), 32'(bus.out_tag), 32'(exp_q_tag.pop_front()));
          chk($sformatf("s%0d_data", c), bus.out_data, exp_q_data.pop_front());
        end
        got++;
      end
      if (fire_in) begin
        exp_q_tag.push_back(5'(sent + 1));
        exp_q_data.push_back(32'hFFFF_FF80 + 32'(sent + 1));
        sent++;
      end
      prev_stall = m_v2 && !bus.out_ready;
      held_data  = bus.out_data;
      held_tag   = bus.out_tag;
      if (!m_v2 || bus.out_ready) begin
        m_v2 = m_v1;
        m_v1 = fire_in;
      end else if (!m_v1) begin
        m_v1 = fire_in;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'd8);

    // Reset with two items in flight
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_tag    = 5'(20 + k);
      bus.in_data   = 32'h7FFF_FFFF;
      bus.in_size   = 2'd2;
      bus.in_offset = 2'd0;
      #1;
      chk($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_data", bus.out_data, 32'h7FFF_FFFF);
    rst = 1'b1;
    #1;
    chk("rst2_in_ready_during", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_out_data", bus.out_data, 32'd0);
    chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rst2_no_stale%0d", k), 32'(bus.out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_extend_pipe.md
Name: load_extend_pipe

Overview:
- Parametrised successor to the combinational sign/zero extender.
- Takes a raw memory read word plus access size, signedness and byte offset. Selects the addressed byte/halfword lane and sign- or zero-extends it to DATA_W.
- Two-stage valid/ready pipeline sitting between data-memory read and the MEM/WB register.
- Full throughput (1 item/cycle) with backpressure; carries a user tag alongside each item.

Parameters:
- DATA_W, 32, datapath width in bits; multiple of 16, >= 16.
- TAG_W, 5, width of sideband tag (e.g. destination register number); >= 1.
- OFF_W, $clog2(DATA_W/8), localparam, byte-offset width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input item present
- in_ready  out  1  stage 1 can accept; handshake fires when in_valid && in_ready
- in_data  in  DATA_W  raw memory word
- in_offset  in  OFF_W  byte address low bits
- in_size  in  2  0=byte, 1=halfword, 2=full word, 3=reserved (treated as 2)
- in_sign  in  1  1=sign-extend, 0=zero-extend
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  output item present
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- out_data  out  DATA_W  extended result
- out_tag  out  TAG_W  tag of the item on out_data
- out_misalign  out  1  present only with ALIGN_CHECK_EN

Behaviour:
- Reset:
  - rst is synchronous, active-high, and overrides all other activity.
  - Clears both stage valids, out_data, out_tag and out_misalign to 0.
  - in_ready is 0 during the rst cycle and 1 in the first cycle after.
  - In-flight items are discarded, not completed.
- Stage 1 (align), registered:
  - Byte: lane = in_data[8*in_offset +: 8].
  - Halfword: lane = in_data[16*in_offset[OFF_W-1:1] +: 16]; in_offset[0] ignored unless the macro is defined.
  - Full: whole word; offset ignored.
  - Registers the lane, a 2-bit effective size, in_sign and in_tag.
- Stage 2 (extend), registered:
  - Upper bits = in_sign ? replicated lane MSB : 0.
  - Full size passes through unchanged regardless of sign.
- Pipeline registers, one valid bit per stage:
  - Stage k loads when its own valid is 0 or the downstream stage drains in the same cycle. Stage 2 drains when out_ready=1.
  - in_ready = !v1 || (!v2 || out_ready). Combinational from stage state and out_ready only; it must not depend on in_valid.
- Latency and throughput: exactly 2 cycles from input handshake to out_valid with no stall; 1 item/cycle sustained.
- Stall:
  - While out_valid && !out_ready, out_data, out_tag and out_misalign hold stable.
  - At most 2 items are buffered; the third is refused via in_ready=0.
- Simultaneous accept and drain on a full pipe: both happen, no bubble inserted, order preserved.
- No reordering, duplication or loss of items; the tag stays paired with its data.

Optional Feature:
- Macro: LOAD_EXTEND_ALIGN_CHECK_EN.
- When defined, port out_misalign exists. It is set for:
  - a halfword access with in_offset[0]=1;
  - a full-word access with in_offset != 0.
- A flagged item still flows through with out_data forced to 0 and its tag intact; the downstream stage raises the address-error exception.
- When not defined:
  - the port is absent;
  - offset low bits are ignored as described above;
  - no error state exists.

Test Plan:
- DATA_W=32, data 0x8077_F0A5, size=0, sign=1, offset=3 -> out_data 0xFFFF_FF80 two cycles after the handshake. Same stimulus with offset=0 -> 0xFFFF_FFA5.
- Same data, size=1, sign=0, offset=2 -> 0x0000_8077. With sign=1 -> 0xFFFF_8077. Offset=0, sign=1 -> 0xFFFF_F0A5.
- Full word, data 0x8000_0001, sign=1, offset=0 -> 0x8000_0001 unchanged.
- Back-to-back stream of tags 1..8 with out_ready toggling 1,0,0,1 -> all 8 items delivered in order with correct tags; in_ready=0 exactly when both stages are full and out_ready=0; outputs stable during stalls.
- Assert rst with 2 items in flight -> next cycle out_valid=0, out_data=0, in_ready=1; no stale item emerges afterwards.
- With LOAD_EXTEND_ALIGN_CHECK_EN: halfword at offset=1 -> out_misalign=1, out_data=0, tag preserved. Word at offset=0 -> out_misalign=0.
